// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit shift/rotate sequencer.
// An accepted operation is applied as binary-weighted stages (8, 4, 2, 1),
// starting at the highest set bit of the amount. The result is held in
// DONE until the consumer accepts it.
module shift_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_amt,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [3:0]  amt_q;
  logic [15:0] val_q;
  logic [1:0]  stage_q;
  logic        accept;

  // Index of the highest set amount bit; leading zero stages are skipped.
  function automatic logic [1:0] hi_bit(input logic [3:0] a);
    logic [1:0] idx;
    if (a[3])      idx = 2'd3;
    else if (a[2]) idx = 2'd2;
    else if (a[1]) idx = 2'd1;
    else           idx = 2'd0;
    return idx;
  endfunction

  // One stage: apply op to v by 2^st (1, 2, 4 or 8).
  function automatic logic [15:0] shift_by(input logic [2:0] op,
                                           input logic [15:0] v,
                                           input logic [1:0] st);
    logic [3:0]  s;
    logic [3:0]  r;
    logic [15:0] res;
    s = 4'd1 << st;
    r = 4'd0 - s;  // 16 - s, the complementary rotate distance
    case (op)
      3'b000:  res = (v << s) | (v >> r);
      3'b001:  res = v << s;
      3'b010:  res = $signed(v) >>> s;
      3'b011:  res = v >> s;
      default: res = (v >> s) | (v << r);
    endcase
    return res;
  endfunction

  // A flush in IDLE suppresses acceptance of a coincident request.
  assign accept = in_valid && (state == IDLE) && !flush;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every other transition.
  // NOTE: state_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = (in_amt == 4'd0) ? DONE : SHIFT;
        SHIFT:   if (stage_q == 2'd0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operation registers: load on accept, one weighted stage per SHIFT cycle.
  // NOTE: all datapath registers are reset so out_data is 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 3'd0;
      amt_q   <= 4'd0;
      val_q   <= 16'd0;
      stage_q <= 2'd0;
    end else if (accept) begin
      op_q    <= in_op;
      amt_q   <= in_amt;
      val_q   <= in_data;
      stage_q <= hi_bit(in_amt);
    end else if (state == SHIFT && !flush) begin
      if (amt_q[stage_q]) val_q <= shift_by(op_q, val_q, stage_q);
      if (stage_q != 2'd0) stage_q <= stage_q - 2'd1;
    end
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == SHIFT) || (state == DONE);
  end

  assign out_data = val_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl. The driver pushes
// hand-computed results and latencies on acceptance; a monitor pops and
// compares whenever out_valid is presented, and checks the held value.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [3:0]  in_amt = 4'd0;
  logic [15:0] in_data = 16'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the first presented result, then its stability.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!active) begin
        check(sb.size() > 0, "unexpected_out_valid", {16'd0, out_data}, 32'd0);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          active = 1'b1;
          check(out_data == cur.data, "result", {16'd0, out_data}, {16'd0, cur.data});
          check(cyc - cur.acc + 1 == cur.lat, "latency", cyc - cur.acc + 1, cur.lat);
        end
      end else begin
        check(out_data == cur.data, "held_result", {16'd0, out_data}, {16'd0, cur.data});
      end
      if (out_ready) active = 1'b0;
    end
  end

  // Drive a request and push its expectation at the accept edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] amt,
                       input logic [15:0] data, input logic [15:0] exp, input int lat);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(in_ready == 1'b1, "ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op = op;
    in_amt = amt;
    in_data = data;
    @(posedge clk); #1;
    e.data = exp;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  // Wait for the sequencer to return to IDLE; in_ready must stay low while busy.
  task automatic wait_done();
    int n = 0;
    while (busy && n < 40) begin
      check(in_ready == 1'b0, "ready_while_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check(!busy && in_ready, "done_timeout", {30'd0, busy, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  amt;
    logic [15:0] data;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{3'b001, 4'd4,  16'h00FF, 16'h0FF0, 4},
    '{3'b010, 4'd15, 16'h8000, 16'hFFFF, 5},
    '{3'b011, 4'd15, 16'h8000, 16'h0001, 5},
    '{3'b000, 4'd1,  16'h8001, 16'h0003, 2},
    '{3'b100, 4'd1,  16'h8001, 16'hC000, 2},
    '{3'b111, 4'd1,  16'h8001, 16'hC000, 2},
    '{3'b010, 4'd0,  16'hA5A5, 16'hA5A5, 1},
    '{3'b000, 4'd8,  16'h1234, 16'h3412, 5},
    '{3'b101, 4'd5,  16'h1234, 16'hA091, 4},
    '{3'b010, 4'd3,  16'h8421, 16'hF084, 3}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state.
    #12;
    check(in_ready == 1'b1, "rst_in_ready", {31'd0, in_ready}, 32'd1);
    check(out_valid == 1'b0, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    check(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
    check(out_data == 16'h0000, "rst_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with free-flowing consumer.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp, vecs[i].lat);
      wait_done();
    end

    // Backpressure: hold DONE for 6 cycles while offering new requests.
    out_ready = 1'b0;
    issue(3'b001, 4'd3, 16'h0001, 16'h0008, 3);
    for (int n = 0; n < 40 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_op = 3'(k);
      in_amt = 4'(k + 1);
      in_data = 16'h1111 * 16'(k + 1);
      @(posedge clk); #1;
      check(out_valid == 1'b1, "hold_out_valid", {31'd0, out_valid}, 32'd1);
      check(busy == 1'b1, "hold_busy", {31'd0, busy}, 32'd1);
      check(in_ready == 1'b0, "hold_in_ready", {31'd0, in_ready}, 32'd0);
      check(out_data == 16'h0008, "hold_out_data", {16'd0, out_data}, 32'h0008);
    end
    in_op = 3'b000;
    in_amt = 4'd0;
    in_data = 16'h5555;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check(out_valid == 1'b0, "release_out_valid", {31'd0, out_valid}, 32'd0);
    check(in_ready == 1'b1, "release_no_overlap", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.data = 16'h5555;
      e.lat = 1;
      e.acc = cyc;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    wait_done();

    // Flush on the second SHIFT cycle.
    issue(3'b011, 4'd12, 16'hFFFF, 16'h000F, 4);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    check(in_ready == 1'b1, "flush_in_ready", {31'd0, in_ready}, 32'd1);
    check(busy == 1'b0, "flush_busy", {31'd0, busy}, 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      check(out_valid == 1'b0, "flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    issue(3'b001, 4'd3, 16'h0001, 16'h0008, 3);
    wait_done();

    // Flush coincident with out_ready in DONE.
    issue(3'b000, 4'd0, 16'h00F0, 16'h00F0, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check(in_ready == 1'b1, "flush_done_in_ready", {31'd0, in_ready}, 32'd1);
    check(out_valid == 1'b0, "flush_done_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in IDLE blocks a coincident request.
    in_valid = 1'b1;
    in_amt = 4'd2;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check(in_ready == 1'b1, "flush_idle_no_accept", {31'd0, in_ready}, 32'd1);
    check(busy == 1'b0, "flush_idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-SHIFT.
    issue(3'b010, 4'd15, 16'h8000, 16'hFFFF, 5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check(in_ready == 1'b1, "arst_in_ready", {31'd0, in_ready}, 32'd1);
    check(out_valid == 1'b0, "arst_out_valid", {31'd0, out_valid}, 32'd0);
    check(busy == 1'b0, "arst_busy", {31'd0, busy}, 32'd0);
    check(out_data == 16'h0000, "arst_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'b110, 4'd4, 16'h00FF, 16'hF00F, 4);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle sequencer that performs a 16-bit shift or rotate by any amount 0–15 using a single binary-weighted shift stage per cycle (8, 4, 2, 1), in the same op encoding as the 8-bit shifter. It sits between the execute-stage issue logic and the shared shift resource. It accepts one operation per valid/ready handshake, skips leading zero amount bits, and holds the result until the consumer accepts it.

## Interface
- No parameters; datapath fixed at 16 bits, amount at 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  sequencer can accept; equals (state == IDLE)
- in_op  input  3  000 ROL, 001 SLL, 010 SRA, 011 SRL, 1xx ROR
- in_amt  input  4  shift amount 0–15
- in_data  input  16  operand
- flush  input  1  synchronous abort to IDLE, result discarded
- out_valid  output  1  result available; equals (state == DONE)
- out_ready  input  1  consumer accepts result
- out_data  output  16  registered result
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Registers: op_q[2:0], amt_q[3:0], val_q[15:0], stage_q[1:0].
- IDLE: accept on in_valid & in_ready. Latch op and amt, and load val_q = in_data.
  - amt == 0: go to DONE.
  - otherwise: stage_q = index of highest set bit of in_amt, and go to SHIFT.
- SHIFT, once per cycle, with s = 2^stage_q:
  - If amt_q[stage_q] = 1, apply op by s to val_q:
    - ROL: rotate left.
    - SLL: shift left, fill 0.
    - SRA: shift right, fill val_q[15].
    - SRL: shift right, fill 0.
    - ROR: rotate right.
  - Otherwise val_q is unchanged.
  - If stage_q == 0, go to DONE; else decrement stage_q.
- DONE: out_data = val_q and is held stable. On out_ready, go to IDLE.
- No overlap: a new request cannot be accepted in the same cycle the result is accepted. in_ready rises the cycle after the out_ready handshake.
- flush is sampled every cycle and forces IDLE from any state. It has priority over in_valid and out_ready in the same cycle. A flush in IDLE with in_valid high does not accept the request. val_q keeps its last value; out_data is don't-care while out_valid is 0.
- in_op, in_amt and in_data are don't-care when no handshake occurs. Inputs changing during SHIFT have no effect.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, all registers 0. in_ready = 1, out_valid = 0, busy = 0, out_data = 0x0000.
- Accept edge E0. Let n = (highest set bit of amt) + 1, and n = 0 for amt = 0.
- Stage updates occur at edges E1..En. out_valid is first high in the cycle after edge En, i.e. n + 1 cycles after the accept edge.
- Per-amount latency: amt 0 → 1 cycle, 1 → 2, 2–3 → 3, 4–7 → 4, 8–15 → 5.
- out_valid stays high and out_data stays constant until the out_ready edge. Both are low in the following cycle.
- rst_n asserted mid-operation returns to IDLE immediately. No out_valid pulse is produced for the aborted operation.
- Backpressure never corrupts the held result; the held value is unaffected by in_* or flush=0.

## Test plan
- Reset release, then SLL 0x00FF amt 4 → out_data 0x0FF0; out_valid first high 4 cycles after the accept edge (n = 3); in_ready low throughout.
- SRA 0x8000 amt 15 → 0xFFFF after 5 cycles. SRL 0x8000 amt 15 → 0x0001. ROL 0x8001 amt 1 → 0x0003 after 2 cycles. ROR (op 1xx, try 100 and 111) 0x8001 amt 1 → 0xC000.
- amt 0 with any op, data 0xA5A5 → out_valid the cycle after accept, out_data 0xA5A5. amt 8, ROL 0x1234 → 0x3412 after 5 cycles (stages 2..0 pass through).
- Hold out_ready low 6 cycles in DONE while driving in_valid high with new operands: out_data constant, no acceptance, busy high. Raise out_ready: next cycle out_valid = 0 and in_ready = 1. New request accepted one cycle later at the earliest.
- flush on the second SHIFT cycle of SRL 0xFFFF amt 12 → IDLE next cycle, no out_valid. A following SLL 0x0001 amt 3 → 0x0008. flush coincident with out_ready in DONE → IDLE.
- rst_n pulsed low mid-SHIFT (asynchronous, not clock-aligned) → outputs at reset values immediately. A subsequent operation completes with correct value and latency.
